mem_io_interconnect: RTL and testbench

Parametrised data-side interconnect between the CPU load/store port, the data RAM and N memory-mapped IO channels. It replaces the fixed one-bit RAM/IO split with a registered request/ready handshake, per-channel address decode, RAM wait states, IO acknowledge with timeout, and a sticky bus-error record. It sits between `Control_unit` and the data RAM / SoC peripherals.

---
 rtl/bus_pkg.sv | 20 ++
 rtl/io_channel_mux.sv | 30 +++
 rtl/mem_io_interconnect.sv | 166 ++++++++++++++++
 tb/tb_mem_io_interconnect.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared FSM states, access-size encodings and IO window default
// for the data-side memory/IO interconnect.
package bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAM_WAIT,
    S_IO_WAIT,
    S_RESP
  } bus_state_t;

  typedef logic [2:0] mem_size_t;

  localparam mem_size_t SZ_BYTE = 3'b000;
  localparam mem_size_t SZ_HALF = 3'b001;
  localparam mem_size_t SZ_WORD = 3'b010;

  localparam logic [7:0] DEF_IO_BASE = 8'hC0;

endpackage

// File: rtl/io_channel_mux.sv
// rtl/io_channel_mux.sv - one-hot IO channel select and ack/read-data return mux;
// an out-of-range channel index selects nothing and returns zero.
module io_channel_mux
  import bus_pkg::*;
#(
  parameter int N_IO = 4
) (
  input  logic [3:0]         i_chan,
  input  logic               i_en,
  input  logic [N_IO-1:0]    i_ack,
  input  logic [N_IO*32-1:0] i_rd,
  output logic [N_IO-1:0]    o_sel,
  output logic               o_ack,
  output logic [31:0]        o_rd
);

  always_comb begin
    o_sel = '0;
    o_ack = 1'b0;
    o_rd  = '0;
    for (int k = 0; k < N_IO; k++) begin
      if (i_chan == 4'(k)) begin
        o_sel[k] = i_en;
        o_ack    = i_en & i_ack[k];
        o_rd     = i_rd[32*k +: 32];
      end
    end
  end

endmodule

// File: rtl/mem_io_interconnect.sv
// rtl/mem_io_interconnect.sv - CPU data port to RAM / N IO channels with registered
// request, RAM wait states, IO ack with timeout and a sticky bus-error record.
module mem_io_interconnect
  import bus_pkg::*;
#(
  parameter int         N_IO        = 4,
  parameter logic [7:0] IO_BASE     = DEF_IO_BASE,
  parameter int         RAM_LATENCY = 1,
  parameter int         TIMEOUT     = 15
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_m_req,
  input  logic [31:0]        i_m_a,
  input  logic               i_m_write,
  input  logic [2:0]         i_m_size,
  input  logic [31:0]        i_m_wd,
  output logic [31:0]        o_m_rd,
  output logic               o_m_ready,
  output logic               o_m_err,
  output logic [31:0]        o_ram_a,
  output logic [31:0]        o_ram_wd,
  output logic [2:0]         o_ram_size,
  output logic               o_ram_write,
  output logic               o_ram_read,
  input  logic [31:0]        i_ram_rd,
  output logic [31:0]        o_io_a,
  output logic [31:0]        o_io_wd,
  output logic [2:0]         o_io_size,
  output logic [N_IO-1:0]    o_io_sel,
  output logic               o_io_write,
  output logic               o_io_read,
  input  logic [N_IO-1:0]    i_io_ack,
  input  logic [N_IO*32-1:0] i_io_rd,
  input  logic               i_err_clear,
  output logic               o_err_sticky,
  output logic [31:0]        o_err_addr
);

  localparam int WAIT_MAX = (TIMEOUT > RAM_LATENCY) ? TIMEOUT : RAM_LATENCY;
  localparam int CW       = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] RAM_LAST = CW'(RAM_LATENCY - 1);
  localparam logic [CW-1:0] IO_LAST  = CW'(TIMEOUT - 1);

  bus_state_t  r_state, w_next;
  logic [31:0] r_addr, r_wd, r_data, r_m_rd, r_err_addr;
  mem_size_t   r_size;
  logic        r_write, r_errflag, r_m_ready, r_m_err, r_err_sticky;
  logic [CW-1:0] r_cnt;

  logic            w_is_io, w_mapped, w_io_en, w_io_ack, w_ram_last, w_io_last;
  logic [31:0]     w_io_rd;
  logic [N_IO-1:0] w_sel;

  assign w_is_io    = (i_m_a[31:24] == IO_BASE);
  assign w_mapped   = ({28'd0, i_m_a[23:20]} < 32'(N_IO));
  assign w_io_en    = (r_state == S_IO_WAIT);
  assign w_ram_last = (r_cnt == RAM_LAST);
  assign w_io_last  = (r_cnt == IO_LAST);

  io_channel_mux #(.N_IO(N_IO)) u_io_mux (
    .i_chan (r_addr[23:20]),
    .i_en   (w_io_en),
    .i_ack  (i_io_ack),
    .i_rd   (i_io_rd),
    .o_sel  (w_sel),
    .o_ack  (w_io_ack),
    .o_rd   (w_io_rd)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // An ack arriving on the timeout cycle still completes the access cleanly.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_m_req) begin
          if (!w_is_io)      w_next = S_RAM_WAIT;
          else if (w_mapped) w_next = S_IO_WAIT;
          else               w_next = S_RESP;
        end
      end
      S_RAM_WAIT: if (w_ram_last) w_next = S_RESP;
      S_IO_WAIT:  if (w_io_ack || w_io_last) w_next = S_RESP;
      S_RESP:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr       <= '0;
      r_wd         <= '0;
      r_size       <= '0;
      r_write      <= 1'b0;
      r_errflag    <= 1'b0;
      r_cnt        <= '0;
      r_data       <= '0;
      r_m_ready    <= 1'b0;
      r_m_err      <= 1'b0;
      r_m_rd       <= '0;
      r_err_sticky <= 1'b0;
      r_err_addr   <= '0;
    end else begin
      r_m_ready <= 1'b0;
      r_m_err   <= 1'b0;
      r_m_rd    <= '0;
      if (i_err_clear) r_err_sticky <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_m_req) begin
            r_addr    <= i_m_a;
            r_wd      <= i_m_wd;
            r_size    <= i_m_size;
            r_write   <= i_m_write;
            r_errflag <= w_is_io && !w_mapped;
            r_cnt     <= '0;
            r_data    <= '0;
          end
        end
        S_RAM_WAIT: begin
          if (r_cnt != {CW{1'b1}}) r_cnt <= r_cnt + 1'b1;
          if (w_ram_last) r_data <= i_ram_rd;
        end
        S_IO_WAIT: begin
          if (r_cnt != {CW{1'b1}}) r_cnt <= r_cnt + 1'b1;
          if (w_io_ack)       r_data    <= w_io_rd;
          else if (w_io_last) r_errflag <= 1'b1;
        end
        S_RESP: begin
          r_m_ready <= 1'b1;
          r_m_err   <= r_errflag;
          r_m_rd    <= (r_errflag || r_write) ? 32'd0 : r_data;
          // A fault recorded here overrides a clear requested on the same edge.
          if (r_errflag) begin
            r_err_sticky <= 1'b1;
            r_err_addr   <= r_addr;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_m_rd       = r_m_rd;
  assign o_m_ready    = r_m_ready;
  assign o_m_err      = r_m_err;
  assign o_ram_a      = r_addr;
  assign o_ram_wd     = r_wd;
  assign o_ram_size   = r_size;
  assign o_ram_read   = (r_state == S_RAM_WAIT) && !r_write;
  assign o_ram_write  = (r_state == S_RAM_WAIT) && r_write;
  assign o_io_a       = r_addr;
  assign o_io_wd      = r_wd;
  assign o_io_size    = r_size;
  assign o_io_sel     = w_sel;
  assign o_io_read    = w_io_en && !r_write;
  assign o_io_write   = w_io_en && r_write;
  assign o_err_sticky = r_err_sticky;
  assign o_err_addr   = r_err_addr;

endmodule

// File: tb/tb_mem_io_interconnect.sv
// tb/tb_mem_io_interconnect.sv - self-checking bench: vector table, random accesses
// against a latency/result model, and hand sequences for reset, clear and back-to-back.
module tb_mem_io_interconnect;

  localparam int N_IO = 4;
  localparam int LAT  = 1;
  localparam int TO   = 15;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               m_req, m_write, err_clear;
  logic [31:0]        m_a, m_wd, ram_rd;
  logic [2:0]         m_size;
  logic [N_IO-1:0]    io_ack;
  logic [N_IO*32-1:0] io_rd;
  logic [31:0]        o_m_rd, o_ram_a, o_ram_wd, o_io_a, o_io_wd, o_err_addr;
  logic [2:0]         o_ram_size, o_io_size;
  logic               o_m_ready, o_m_err, o_ram_write, o_ram_read, o_io_write, o_io_read, o_err_sticky;
  logic [N_IO-1:0]    o_io_sel;

  int n_tests = 0;
  int n_fail  = 0;

  int          r_lat, r_str, r_bsel, r_bdir;
  logic        r_err;
  logic [31:0] r_rd;
  logic        m_sticky;
  logic [31:0] m_err_addr;

  always #5 clk = ~clk;

  mem_io_interconnect #(
    .N_IO(N_IO), .IO_BASE(8'hC0), .RAM_LATENCY(LAT), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_m_req(m_req), .i_m_a(m_a), .i_m_write(m_write),
    .i_m_size(m_size), .i_m_wd(m_wd), .o_m_rd(o_m_rd), .o_m_ready(o_m_ready),
    .o_m_err(o_m_err), .o_ram_a(o_ram_a), .o_ram_wd(o_ram_wd), .o_ram_size(o_ram_size),
    .o_ram_write(o_ram_write), .o_ram_read(o_ram_read), .i_ram_rd(ram_rd),
    .o_io_a(o_io_a), .o_io_wd(o_io_wd), .o_io_size(o_io_size), .o_io_sel(o_io_sel),
    .o_io_write(o_io_write), .o_io_read(o_io_read), .i_io_ack(io_ack), .i_io_rd(io_rd),
    .i_err_clear(err_clear), .o_err_sticky(o_err_sticky), .o_err_addr(o_err_addr)
  );

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] wd;
    logic [31:0] rrd;
    int          ack_d;
    int          e_lat;
    logic        e_err;
    logic [31:0] e_rd;
    int          e_str;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Spec-level outcome of one access: cycle of M_Ready counted from the request cycle.
  function automatic void model(input logic [31:0] a, input logic w, input logic [31:0] rrd,
                                input int ack_d, input logic [N_IO*32-1:0] iord,
                                output int lat, output logic err, output logic [31:0] rd,
                                output int str);
    int ch;
    ch = int'(a[23:20]);
    if (a[31:24] != 8'hC0) begin
      lat = LAT + 2; err = 1'b0; rd = w ? 32'd0 : rrd; str = LAT;
    end else if (ch >= N_IO) begin
      lat = 2; err = 1'b1; rd = 32'd0; str = 0;
    end else if (ack_d >= 1 && ack_d <= TO) begin
      lat = ack_d + 2; err = 1'b0; rd = w ? 32'd0 : iord[32*ch +: 32]; str = ack_d;
    end else begin
      lat = TO + 2; err = 1'b1; rd = 32'd0; str = TO;
    end
  endfunction

  task automatic do_access(input logic [31:0] a, input logic w, input logic [2:0] sz,
                           input logic [31:0] wd, input logic [31:0] rrd,
                           input int ack_d, input int clr_at);
    logic [N_IO-1:0] exp_sel;
    logic            is_io, io_stb, ram_stb;
    exp_sel = '0;
    is_io   = (a[31:24] == 8'hC0);
    if (is_io && int'(a[23:20]) < N_IO) exp_sel[a[23:20]] = 1'b1;
    r_lat = -1; r_str = 0; r_bsel = 0; r_bdir = 0; r_err = 1'b0; r_rd = '0;
    @(posedge clk); #1;
    m_req = 1'b1; m_a = a; m_write = w; m_size = sz; m_wd = wd; ram_rd = rrd; io_ack = '0;
    @(negedge clk);
    if (o_m_ready) r_lat = 0;
    for (int c = 1; c <= 40 && r_lat < 0; c++) begin
      @(posedge clk); #1;
      m_req     = 1'b0;
      io_ack    = N_IO'($urandom) & ~exp_sel;
      if (ack_d > 0 && c >= ack_d) io_ack = io_ack | exp_sel;
      err_clear = (c == clr_at);
      @(negedge clk);
      io_stb  = o_io_read | o_io_write;
      ram_stb = o_ram_read | o_ram_write;
      if (io_stb | ram_stb) r_str++;
      if (io_stb && o_io_sel !== exp_sel) r_bsel++;
      if (!io_stb && o_io_sel !== '0) r_bsel++;
      if (w ? (o_ram_read | o_io_read) : (o_ram_write | o_io_write)) r_bdir++;
      if (is_io ? ram_stb : io_stb) r_bdir++;
      if (o_m_ready) begin
        r_lat = c; r_err = o_m_err; r_rd = o_m_rd;
      end
    end
    @(posedge clk); #1;
    io_ack = '0; err_clear = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] wd,
                              input logic [2:0] sz, input int e_lat, input logic e_err,
                              input logic [31:0] e_rd, input int e_str);
    chk({tag, ".latency"}, 64'(r_lat), 64'(e_lat));
    chk({tag, ".err"}, 64'(r_err), 64'(e_err));
    chk({tag, ".rd"}, 64'(r_rd), 64'(e_rd));
    chk({tag, ".strobe_cycles"}, 64'(r_str), 64'(e_str));
    chk({tag, ".sel_dir_errors"}, 64'(r_bsel + r_bdir), 64'd0);
    if (e_err) begin
      m_sticky   = 1'b1;
      m_err_addr = a;
    end
    chk({tag, ".sticky_addr"}, {31'd0, o_err_sticky, o_err_addr}, {31'd0, m_sticky, m_err_addr});
    chk({tag, ".req_regs"}, {o_ram_a, o_io_a}, {a, a});
    chk({tag, ".req_data"}, {29'd0, o_ram_wd, o_io_size}, {29'd0, wd, sz});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          e_lat, e_str, kind, ack_d, nrdy, first, second, bad_rd;
    logic        e_err, w;
    logic [31:0] e_rd, a, wd, rrd;
    logic [2:0]  sz;

    m_req = 0; m_a = 0; m_write = 0; m_size = 0; m_wd = 0; ram_rd = 0;
    io_ack = 0; err_clear = 0;
    io_rd = {32'h4040_4040, 32'h3030_3030, 32'h2020_2020, 32'h1010_1010};
    m_sticky = 1'b0; m_err_addr = '0;

    vecs[0] = '{32'h0000_0010, 1'b0, 32'h0000_0000, 32'h1234_5678, 0, 3, 1'b0, 32'h1234_5678, 1};
    vecs[1] = '{32'h0000_0020, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 0, 3, 1'b0, 32'h0000_0000, 1};
    vecs[2] = '{32'hC020_0004, 1'b1, 32'hA5A5_0001, 32'h0000_0000, 5, 7, 1'b0, 32'h0000_0000, 5};
    vecs[3] = '{32'hC010_0008, 1'b0, 32'h0000_0000, 32'h0000_0000, 1, 3, 1'b0, 32'h2020_2020, 1};
    vecs[4] = '{32'hC010_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 17, 1'b1, 32'h0000_0000, 15};
    vecs[5] = '{32'hC050_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 2, 1'b1, 32'h0000_0000, 0};
    vecs[6] = '{32'hC030_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 15, 17, 1'b0, 32'h4040_4040, 15};
    vecs[7] = '{32'hC100_0000, 1'b0, 32'h0000_0000, 32'h55AA_55AA, 0, 3, 1'b0, 32'h55AA_55AA, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.resp", {30'd0, o_m_ready, o_m_err, o_m_rd}, 64'd0);
    chk("reset.strobes", {56'd0, o_ram_read, o_ram_write, o_io_read, o_io_write, o_io_sel}, 64'd0);
    chk("reset.addr", {o_ram_a, o_io_a}, 64'd0);
    chk("reset.err", {31'd0, o_err_sticky, o_err_addr}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_access(vecs[i].a, vecs[i].w, 3'b010, vecs[i].wd, vecs[i].rrd, vecs[i].ack_d, 0);
      check_result($sformatf("vec%0d", i), vecs[i].a, vecs[i].wd, 3'b010,
                   vecs[i].e_lat, vecs[i].e_err, vecs[i].e_rd, vecs[i].e_str);
    end

    // Lone clear drops the sticky flag but keeps the fault address.
    @(posedge clk); #1; err_clear = 1'b1;
    @(posedge clk); #1; err_clear = 1'b0;
    m_sticky = 1'b0;
    @(negedge clk);
    chk("clear.lone", {31'd0, o_err_sticky, o_err_addr}, {31'd0, m_sticky, m_err_addr});

    // Clear asserted on the fault's response cycle: the new error must win.
    do_access(32'hC050_0000, 1'b0, 3'b000, 32'd0, 32'd0, 0, 1);
    check_result("clear_vs_fault", 32'hC050_0000, 32'd0, 3'b000, 2, 1'b1, 32'd0, 0);
    @(posedge clk); #1; err_clear = 1'b1;
    @(posedge clk); #1; err_clear = 1'b0;
    m_sticky = 1'b0;
    @(negedge clk);
    chk("clear.after_fault", {31'd0, o_err_sticky, o_err_addr}, {31'd0, m_sticky, m_err_addr});

    // Back-to-back RAM loads with M_Req held across the response.
    @(posedge clk); #1;
    m_req = 1'b1; m_a = 32'h0000_0100; m_write = 1'b0; ram_rd = 32'hCAFE_F00D;
    nrdy = 0; first = -1; second = -1; bad_rd = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == LAT + 3) m_req = 1'b0;
      @(negedge clk);
      if (o_m_ready) begin
        nrdy++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
        if (o_m_rd !== 32'hCAFE_F00D) bad_rd++;
      end
    end
    chk("b2b.count", 64'(nrdy), 64'd2);
    chk("b2b.first", 64'(first), 64'(LAT + 2));
    chk("b2b.second", 64'(second), 64'(2 * (LAT + 2)));
    chk("b2b.rd", 64'(bad_rd), 64'd0);

    // Reset in the middle of an IO read.
    @(posedge clk); #1;
    m_req = 1'b1; m_a = 32'hC020_0000; m_write = 1'b0;
    @(posedge clk); #1; m_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst.before", {59'd0, o_io_read, o_io_sel}, {59'd0, 1'b1, 4'b0100});
    #2 rst = 1'b1;
    #1;
    chk("midrst.strobes", {58'd0, o_m_ready, o_m_err, o_ram_read, o_ram_write, o_io_read, o_io_write, o_io_sel}, 64'd0);
    chk("midrst.addr", {o_io_a, o_ram_a}, 64'd0);
    m_sticky = 1'b0; m_err_addr = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_access(32'h0000_0040, 1'b0, 3'b010, 32'd0, 32'h0BAD_F00D, 0, 0);
    check_result("midrst.after", 32'h0000_0040, 32'd0, 3'b010, LAT + 2, 1'b0, 32'h0BAD_F00D, LAT);

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 2));
      a    = $urandom;
      if (kind == 0) begin
        if (a[31:24] == 8'hC0) a[31:24] = 8'h00;
      end else begin
        a[31:24] = 8'hC0;
        if (kind == 1) a[23:20] = 4'($urandom_range(0, N_IO - 1));
        else           a[23:20] = 4'($urandom_range(N_IO, 15));
      end
      w     = 1'($urandom_range(0, 1));
      sz    = 3'($urandom);
      wd    = $urandom;
      rrd   = $urandom;
      ack_d = int'($urandom_range(0, TO + 2));
      for (int k = 0; k < N_IO; k++) io_rd[32*k +: 32] = $urandom;
      model(a, w, rrd, ack_d, io_rd, e_lat, e_err, e_rd, e_str);
      do_access(a, w, sz, wd, rrd, ack_d, 0);
      check_result($sformatf("rand%0d", i), a, wd, sz, e_lat, e_err, e_rd, e_str);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
